// File: rtl/multi_xor_unit.sv
// Triple-redundant registered XOR: gate, behavioural and dataflow paths,
// bitwise 2-of-3 voter, disagreement flag and saturating mismatch counter.
module multi_xor_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       fault_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] y_gate,
    output logic [WIDTH-1:0] y_beh,
    output logic [WIDTH-1:0] y_df,
    output logic [WIDTH-1:0] y,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        FAULT_NONE = 2'd0,
        FAULT_GATE = 2'd1,
        FAULT_BEH  = 2'd2,
        FAULT_DF   = 2'd3
    } fault_e;

    fault_e           fault;
    logic [WIDTH-1:0] gate_raw, beh_raw, df_raw;
    logic [WIDTH-1:0] gate_f, beh_f, df_f;
    logic [WIDTH-1:0] vote;
    logic             disagree;

    assign fault = fault_e'(fault_sel);

    for (genvar i = 0; i < WIDTH; i++) begin : g_gate
        xor u_xor (gate_raw[i], a[i], b[i]);
    end

    // Truth-table per bit so this path shares no operator with the others
    always_comb begin
        beh_raw = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({a[i], b[i]})
                2'b01, 2'b10: beh_raw[i] = 1'b1;
                default:      beh_raw[i] = 1'b0;
            endcase
        end
    end

    assign df_raw = a ^ b;

    assign gate_f = gate_raw ^ {WIDTH{fault == FAULT_GATE}};
    assign beh_f  = beh_raw  ^ {WIDTH{fault == FAULT_BEH}};
    assign df_f   = df_raw   ^ {WIDTH{fault == FAULT_DF}};

    assign vote     = (gate_f & beh_f) | (gate_f & df_f) | (beh_f & df_f);
    assign disagree = (gate_f != beh_f) || (gate_f != df_f);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            y_gate       <= '0;
            y_beh        <= '0;
            y_df         <= '0;
            y            <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            mismatch  <= in_valid && disagree;
            if (in_valid) begin
                y_gate <= gate_f;
                y_beh  <= beh_f;
                y_df   <= df_f;
                y      <= vote;
                if (disagree && (mismatch_cnt != '1))
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_xor_unit.sv
// Scoreboard bench for multi_xor_unit: a 1-bit instance with an 8-bit counter
// and an 8-bit instance with a 2-bit counter, driven in lockstep.
module tb_multi_xor_unit;

    logic       clk = 1'b0;
    logic       rst, in_valid;
    logic [1:0] fault_sel;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic       ov1, mm1, ov8, mm8;
    logic [0:0] yg1, yb1, yd1, y1;
    logic [7:0] cnt1;
    logic [7:0] yg8, yb8, yd8, y8;
    logic [1:0] cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_xor_unit #(.WIDTH(1), .CNT_W(8)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
        .fault_sel(fault_sel), .out_valid(ov1), .y_gate(yg1), .y_beh(yb1),
        .y_df(yd1), .y(y1), .mismatch(mm1), .mismatch_cnt(cnt1)
    );

    multi_xor_unit #(.WIDTH(8), .CNT_W(2)) u_wide (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
        .fault_sel(fault_sel), .out_valid(ov8), .y_gate(yg8), .y_beh(yb8),
        .y_df(yd8), .y(y8), .mismatch(mm8), .mismatch_cnt(cnt8)
    );

    typedef struct {
        logic       ov, mm;
        logic [0:0] g1, b1, d1, y1;
        logic [7:0] c1;
        logic [7:0] g8, b8, d8, y8;
        logic [1:0] c8;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;   // running model state

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, advance the model, push expectation, then compare after the edge
    task automatic step(input logic r, input logic v, input logic [1:0] fs,
                        input logic ia1, input logic ib1,
                        input logic [7:0] ia8, input logic [7:0] ib8);
        logic [0:0] x1;
        logic [7:0] x8;
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; fault_sel = fs;
        a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
        if (r) begin
            m = '{default: '0};
        end else begin
            m.ov = v;
            m.mm = v && (fs != 2'd0);
            if (v) begin
                x1 = ia1 ^ ib1;
                x8 = ia8 ^ ib8;
                m.y1 = x1;
                m.y8 = x8;
                m.g1 = (fs == 2'd1) ? ~x1 : x1;
                m.b1 = (fs == 2'd2) ? ~x1 : x1;
                m.d1 = (fs == 2'd3) ? ~x1 : x1;
                m.g8 = (fs == 2'd1) ? ~x8 : x8;
                m.b8 = (fs == 2'd2) ? ~x8 : x8;
                m.d8 = (fs == 2'd3) ? ~x8 : x8;
                if (fs != 2'd0) begin
                    if (m.c1 != 8'hFF) m.c1 = m.c1 + 8'd1;
                    if (m.c8 != 2'd3)  m.c8 = m.c8 + 2'd1;
                end
            end
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("ov1",    {7'd0, ov1}, {7'd0, e.ov});
        chk("mm1",    {7'd0, mm1}, {7'd0, e.mm});
        chk("y1",     {7'd0, y1},  {7'd0, e.y1});
        chk("ygate1", {7'd0, yg1}, {7'd0, e.g1});
        chk("ybeh1",  {7'd0, yb1}, {7'd0, e.b1});
        chk("ydf1",   {7'd0, yd1}, {7'd0, e.d1});
        chk("cnt1",   cnt1,        e.c1);
        chk("ov8",    {7'd0, ov8}, {7'd0, e.ov});
        chk("mm8",    {7'd0, mm8}, {7'd0, e.mm});
        chk("y8",     y8,          e.y8);
        chk("ygate8", yg8,         e.g8);
        chk("ybeh8",  yb8,         e.b8);
        chk("ydf8",   yd8,         e.d8);
        chk("cnt8",   {6'd0, cnt8}, {6'd0, e.c8});
    endtask

    initial begin
        m = '{default: '0};
        rst = 1'b1; in_valid = 1'b0; fault_sel = 2'd0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;

        // Reset with valid operands present
        step(1, 1, 0, 1, 1, 8'hFF, 8'h00);
        step(1, 1, 0, 1, 1, 8'hFF, 8'h00);

        // Truth table, fault-free
        step(0, 1, 0, 0, 0, 8'hA5, 8'h0F);
        step(0, 1, 0, 0, 1, 8'h3C, 8'hC3);
        step(0, 1, 0, 1, 0, 8'hFF, 8'h00);
        step(0, 1, 0, 1, 1, 8'h5A, 8'h5A);

        // Hold while idle
        step(0, 1, 0, 1, 0, 8'h12, 8'h34);
        step(0, 0, 0, 1, 1, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 1, 8'h00, 8'hFF);
        step(0, 0, 2, 0, 0, 8'h77, 8'h11);

        // Single-path faults masked by voter; wide counter saturates at 3
        step(0, 1, 2, 1, 1, 8'hA5, 8'h0F);
        step(0, 1, 1, 1, 1, 8'hA5, 8'h0F);
        step(0, 1, 3, 1, 1, 8'hA5, 8'h0F);
        step(0, 1, 3, 0, 1, 8'hA5, 8'h0F);
        step(0, 1, 1, 1, 0, 8'hF0, 8'h0F);

        // Fault-free transaction keeps counters, clears mismatch
        step(0, 1, 0, 0, 1, 8'h81, 8'h18);

        // Mid-stream reset
        step(1, 1, 2, 1, 0, 8'hAA, 8'h55);
        step(0, 1, 0, 1, 0, 8'hA5, 8'h0F);
        step(0, 1, 3, 1, 1, 8'hA5, 8'h0F);

        // Random fault-free and faulted traffic
        for (int i = 0; i < 12; i++)
            step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
